turf_udp_port_demux: RTL

Parametrised UDP receive-side port demultiplexer. It sits directly after the UDP receive header/payload streams of the TURF UDP core. Each incoming UDP header's destination port is matched against a compile-time port table, and the header plus its payload frame are steered to one of NUM_PORTS output channels. Unmatched frames are drained and counted. This generalises the single-output UDP path to N independent per-port consumers with drop handling.

---
 rtl/turf_udp_pkg.sv | 28 ++
 rtl/udp_port_match.sv | 26 ++
 rtl/turf_udp_port_demux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/turf_udp_pkg.sv
// rtl/turf_udp_pkg.sv - shared state encoding, header layout and constants for the UDP port demux
package turf_udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // UDP header word layout: {src ip, src port, length}
  localparam int HDR_WIDTH = 64;
  localparam int IP_OFF    = 32;
  localparam int SPORT_OFF = 16;
  localparam int LEN_OFF   = 0;

  // Channel i listens on DEFAULT_PORT_LIST[16*i +: 16]
  localparam int                DEFAULT_NUM_PORTS = 4;
  localparam logic [4*16-1:0]   DEFAULT_PORT_LIST = {16'd21624, 16'd21622, 16'd21620, 16'd21618};

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == COUNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// rtl/udp_port_match.sv - parallel destination-port lookup with lowest-index priority
module udp_port_match
  import turf_udp_pkg::*;
#(
  parameter int                       NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter logic [NUM_PORTS*16-1:0]  PORT_LIST = DEFAULT_PORT_LIST,
  localparam int                      SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [15:0]      port,
  output logic             hit,
  output logic [SEL_W-1:0] idx
);

  // Scan from the top so the lowest matching entry is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port == PORT_LIST[16*i +: 16]) begin
        hit = 1'b1;
        idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/turf_udp_port_demux.sv
// rtl/turf_udp_port_demux.sv - UDP rx port demux to NUM_PORTS channels; UDP_PORT_DEMUX_STATS_EN adds frame counters and stats_clear
module turf_udp_port_demux
  import turf_udp_pkg::*;
#(
  parameter int                       NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter logic [NUM_PORTS*16-1:0]  PORT_LIST  = DEFAULT_PORT_LIST,
  parameter int                       DATA_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [63:0]                         s_udphdr_tdata,
  input  logic [15:0]                         s_udphdr_tdest,
  input  logic                                s_udphdr_tvalid,
  output logic                                s_udphdr_tready,
  input  logic [DATA_WIDTH-1:0]               s_udpdata_tdata,
  input  logic [DATA_WIDTH/8-1:0]             s_udpdata_tkeep,
  input  logic                                s_udpdata_tlast,
  input  logic                                s_udpdata_tvalid,
  output logic                                s_udpdata_tready,
  output logic [NUM_PORTS*64-1:0]             m_udphdr_tdata,
  output logic [NUM_PORTS-1:0]                m_udphdr_tvalid,
  input  logic [NUM_PORTS-1:0]                m_udphdr_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     m_udpdata_tdata,
  output logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] m_udpdata_tkeep,
  output logic [NUM_PORTS-1:0]                m_udpdata_tlast,
  output logic [NUM_PORTS-1:0]                m_udpdata_tvalid,
  input  logic [NUM_PORTS-1:0]                m_udpdata_tready,
`ifdef UDP_PORT_DEMUX_STATS_EN
  input  logic                                stats_clear,
  output logic [NUM_PORTS*32-1:0]             frame_count,
`endif
  output logic [31:0]                         drop_count
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t            state;
  state_t            state_next;
  logic [63:0]       hdr_reg;
  logic [SEL_W-1:0]  sel;
  logic              match_hit;
  logic [SEL_W-1:0]  match_idx;
  logic              hdr_fire;
  logic              drop_done;

  udp_port_match #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_LIST (PORT_LIST)
  ) u_match (
    .port (s_udphdr_tdest),
    .hit  (match_hit),
    .idx  (match_idx)
  );

  assign hdr_fire  = s_udphdr_tvalid && s_udphdr_tready;
  assign drop_done = (state == ST_DROP) && s_udpdata_tvalid && s_udpdata_tlast;

  // Data is broadcast; only the valid of the selected channel qualifies it
  assign m_udphdr_tdata  = {NUM_PORTS{hdr_reg}};
  assign m_udpdata_tdata = {NUM_PORTS{s_udpdata_tdata}};
  assign m_udpdata_tkeep = {NUM_PORTS{s_udpdata_tkeep}};
  assign m_udpdata_tlast = {NUM_PORTS{s_udpdata_tlast}};

  // Next state and handshake steering; everything is held off while in reset
  always_comb begin
    state_next       = state;
    s_udphdr_tready  = 1'b0;
    s_udpdata_tready = 1'b0;
    m_udphdr_tvalid  = '0;
    m_udpdata_tvalid = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          s_udphdr_tready = 1'b1;
          if (s_udphdr_tvalid) begin
            state_next = match_hit ? ST_HDR : ST_DROP;
          end
        end
        ST_HDR: begin
          m_udphdr_tvalid[sel] = 1'b1;
          if (m_udphdr_tready[sel]) begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          m_udpdata_tvalid[sel] = s_udpdata_tvalid;
          s_udpdata_tready      = m_udpdata_tready[sel];
          if (s_udpdata_tvalid && m_udpdata_tready[sel] && s_udpdata_tlast) begin
            state_next = ST_IDLE;
          end
        end
        ST_DROP: begin
          s_udpdata_tready = 1'b1;
          if (s_udpdata_tvalid && s_udpdata_tlast) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register plus header/channel capture on header acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hdr_reg <= '0;
      sel     <= '0;
    end else begin
      state <= state_next;
      if (hdr_fire) begin
        hdr_reg <= s_udphdr_tdata;
        sel     <= match_idx;
      end
    end
  end

  // Saturating count of frames drained for lack of a matching port
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
`ifdef UDP_PORT_DEMUX_STATS_EN
    end else if (stats_clear) begin
      drop_count <= '0;
`endif
    end else if (drop_done) begin
      drop_count <= sat_inc(drop_count);
    end
  end

`ifdef UDP_PORT_DEMUX_STATS_EN
  logic frame_done;

  assign frame_done = (state == ST_DATA) && s_udpdata_tvalid && s_udpdata_tready && s_udpdata_tlast;

  // Per-channel saturating count of delivered frames; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stats_clear) begin
      frame_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (frame_done && (sel == SEL_W'(i))) begin
          frame_count[32*i +: 32] <= sat_inc(frame_count[32*i +: 32]);
        end
      end
    end
  end
`endif

endmodule
